spart_responder: RTL and testbench

//  Bus-side responder and serial engine answering the host driver's iocs/iorw/ioaddr/databus accesses.

---
 rtl/spart_pkg.sv | 28 ++
 rtl/spart_baud_gen.sv | 31 +++
 rtl/spart_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_spart_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared register addresses, frame timing constants and FSM state types for the SPART responder.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int unsigned DIV_W      = 16;
    localparam int unsigned TCNT_W     = 4;
    localparam int unsigned BIT_TICKS  = 16;
    localparam int unsigned HALF_TICKS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// 16x baud tick generator: one-clock tick every divisor+1 clocks, phase reset on restart.
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             restart,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Count down to zero, pulse, reload; restart forces a fresh period from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= divisor;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - DIV_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/spart_responder.sv
// SPART bus responder with 8N1 TX/RX engines. Optional sticky framing-error
// status bit when SPART_FERR_EN is defined.
module spart_responder
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd325,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic [7:0]       tx_buf;
    logic [7:0]       rx_buf;
    logic [7:0]       div_lo;
    logic [DIV_W-1:0] divisor;
    logic [7:0]       rd_data_c;
    logic             ferr_c;
    logic             tick;

    logic wr_en_c, rd_en_c, tx_load_c, div_wr_c, data_rd_c;
    assign wr_en_c   = iocs && !iorw;
    assign rd_en_c   = iocs && iorw;
    assign tx_load_c = wr_en_c && (ioaddr == ADDR_DATA) && tbr;
    assign div_wr_c  = wr_en_c && (ioaddr == ADDR_DBH);
    assign data_rd_c = rd_en_c && (ioaddr == ADDR_DATA);

    always_comb begin
        rd_data_c = 8'h00;
        case (ioaddr)
            ADDR_DATA: rd_data_c = rx_buf;
            ADDR_STAT: rd_data_c = {5'b0, ferr_c, tbr, rda};
            ADDR_DBL:  rd_data_c = divisor[7:0];
            default:   rd_data_c = divisor[15:8];
        endcase
    end

    assign databus = rd_en_c ? rd_data_c : 8'bz;

    spart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor),
        .restart (div_wr_c),
        .tick    (tick)
    );

    // ---------------- TX engine ----------------
    tx_state_t         tx_state, tx_state_nx;
    logic [TCNT_W-1:0] tx_tcnt, tx_tcnt_nx;
    logic [2:0]        tx_idx, tx_idx_nx, tx_idx_inc_c;
    logic              txd_nx, tx_stop_entry_c;

    assign tx_idx_inc_c = tx_idx + 3'd1;

    always_comb begin
        tx_state_nx     = tx_state;
        tx_tcnt_nx      = tx_tcnt;
        tx_idx_nx       = tx_idx;
        txd_nx          = txd;
        tx_stop_entry_c = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tick && !tbr) begin
                    tx_state_nx = TX_START;
                    tx_tcnt_nx  = '0;
                    txd_nx      = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_tcnt == TCNT_W'(BIT_TICKS - 1)) begin
                        tx_state_nx = TX_DATA;
                        tx_tcnt_nx  = '0;
                        tx_idx_nx   = '0;
                        txd_nx      = tx_buf[0];
                    end else begin
                        tx_tcnt_nx = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tcnt == TCNT_W'(BIT_TICKS - 1)) begin
                        tx_tcnt_nx = '0;
                        if (tx_idx == 3'd7) begin
                            tx_state_nx     = TX_STOP;
                            txd_nx          = 1'b1;
                            tx_stop_entry_c = 1'b1;
                        end else begin
                            tx_idx_nx = tx_idx_inc_c;
                            txd_nx    = tx_buf[tx_idx_inc_c];
                        end
                    end else begin
                        tx_tcnt_nx = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tcnt == TCNT_W'(BIT_TICKS - 1)) begin
                        tx_state_nx = TX_IDLE;
                        tx_tcnt_nx  = '0;
                    end else begin
                        tx_tcnt_nx = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_idx   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_tcnt  <= tx_tcnt_nx;
            tx_idx   <= tx_idx_nx;
            txd      <= txd_nx;
        end
    end

    // Host registers; a load in the cycle the stop bit starts keeps tbr low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_buf  <= 8'h00;
            div_lo  <= DEFAULT_DIV[7:0];
            divisor <= DEFAULT_DIV;
            tbr     <= 1'b1;
        end else begin
            if (tx_load_c) tx_buf <= databus;
            if (wr_en_c && (ioaddr == ADDR_DBL)) div_lo <= databus;
            if (div_wr_c) divisor <= {databus, div_lo};
            if (tx_load_c)            tbr <= 1'b0;
            else if (tx_stop_entry_c) tbr <= 1'b1;
        end
    end

    // ---------------- RX engine ----------------
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_prev, rxs_c, rx_fall_c;

    assign rxs_c     = rx_sync[SYNC_STAGES-1];
    assign rx_fall_c = rx_prev && !rxs_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rxd};
            rx_prev <= rxs_c;
        end
    end

    rx_state_t         rx_state, rx_state_nx;
    logic [TCNT_W-1:0] rx_tcnt, rx_tcnt_nx;
    logic [2:0]        rx_idx, rx_idx_nx;
    logic [7:0]        rx_shift, rx_shift_nx;
    logic              rx_commit_c, rx_bad_c;

    always_comb begin
        rx_state_nx = rx_state;
        rx_tcnt_nx  = rx_tcnt;
        rx_idx_nx   = rx_idx;
        rx_shift_nx = rx_shift;
        rx_commit_c = 1'b0;
        rx_bad_c    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall_c) begin
                    rx_state_nx = RX_START;
                    rx_tcnt_nx  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tcnt == TCNT_W'(HALF_TICKS - 1)) begin
                        rx_state_nx = rxs_c ? RX_IDLE : RX_DATA;
                        rx_tcnt_nx  = '0;
                        rx_idx_nx   = '0;
                    end else begin
                        rx_tcnt_nx = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tcnt == TCNT_W'(BIT_TICKS - 1)) begin
                        rx_tcnt_nx  = '0;
                        rx_shift_nx = {rxs_c, rx_shift[7:1]};
                        if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
                        else                rx_idx_nx   = rx_idx + 3'd1;
                    end else begin
                        rx_tcnt_nx = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tcnt == TCNT_W'(BIT_TICKS - 1)) begin
                        rx_state_nx = RX_IDLE;
                        rx_tcnt_nx  = '0;
                        rx_commit_c = rxs_c;
                        rx_bad_c    = !rxs_c;
                    end else begin
                        rx_tcnt_nx = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // A committing byte beats a concurrent host read, so rda stays set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_idx   <= '0;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rda      <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_tcnt  <= rx_tcnt_nx;
            rx_idx   <= rx_idx_nx;
            rx_shift <= rx_shift_nx;
            if (rx_commit_c) rx_buf <= rx_shift;
            if (rx_commit_c)    rda <= 1'b1;
            else if (data_rd_c) rda <= 1'b0;
        end
    end

`ifdef SPART_FERR_EN
    logic ferr;
    logic stat_rd_c;
    assign stat_rd_c = rd_en_c && (ioaddr == ADDR_STAT);

    always_ff @(posedge clk) begin
        if (!rst)           ferr <= 1'b0;
        else if (rx_bad_c)  ferr <= 1'b1;
        else if (stat_rd_c) ferr <= 1'b0;
    end
    assign ferr_c = ferr;
`else
    logic unused_ferr_c;
    assign unused_ferr_c = rx_bad_c;
    assign ferr_c        = 1'b0;
`endif

endmodule

// File: tb/tb_spart_responder.sv
// Scoreboard bench for spart_responder: random TX/RX traffic against a byte-level reference model.
module tb_spart_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic       rxd = 1'b1;
    logic [7:0] tb_data = 8'h00;
    logic       tb_drive = 1'b0;
    wire  [7:0] databus;
    logic       rda, tbr, txd;

    assign databus = tb_drive ? tb_data : 8'bz;

    always #5 clk = ~clk;

    spart_responder #(.DEFAULT_DIV(16'd0), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } rd_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         bit_clks = 16;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_exp_q[$];
    rd_t        rd_q[$];

    // Reference model: what the host should see, in byte terms
    logic [7:0] m_rx = 8'h00;
    logic       m_rda = 1'b0;
    logic       m_ferr = 1'b0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Read monitor: every host read cycle is checked against the queued expectation
    always @(negedge clk) begin
        if (rst_n && iocs && iorw) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: addr %0d data %0h", ioaddr, databus);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                check($sformatf("read_addr%0d", e.addr), {8'h00, databus}, {8'h00, e.data});
            end
        end
    end

    // TX monitor: mid-bit sampling of each txd frame
    initial begin
        forever begin
            @(negedge txd);
            if (rst_n) begin
                logic [9:0] got;
                logic [7:0] e;
                tx_busy = 1'b1;
                repeat (bit_clks / 2) @(posedge clk);
                @(negedge clk);
                got[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (bit_clks) @(posedge clk);
                    @(negedge clk);
                    got[i] = txd;
                    if (i == 8) check("tbr_last_data_bit", {15'h0, tbr}, 16'h0);
                    if (i == 9) check("tbr_stop_bit", {15'h0, tbr}, 16'h1);
                end
                if (tx_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx_frame: got %0h", got);
                end else begin
                    e = tx_exp_q.pop_front();
                    check("tx_frame", {6'h0, got}, {6'h0, 1'b1, e, 1'b0});
                end
                tx_busy = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_data = d; tb_drive = 1'b1;
        @(posedge clk); #1;
        iocs = 1'b0; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        rd_q.push_back('{addr: a, data: exp});
        @(posedge clk); #1;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(2'b10, d[7:0]);
        bus_write(2'b11, d[15:8]);
        bit_clks = 16 * (int'(d) + 1);
        bus_read(2'b10, d[7:0]);
        bus_read(2'b11, d[15:8]);
    endtask

    task automatic read_status();
        bus_read(2'b01, {5'b0, m_ferr, 1'b1, m_rda});
        m_ferr = 1'b0;
    endtask

    task automatic read_data();
        bus_read(2'b00, m_rx);
        m_rda = 1'b0;
    endtask

    // Drive one 8N1 frame; the model learns the outcome once the frame is over
    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (bit_clks) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (2 * bit_clks) @(posedge clk);
        if (stop) begin
            m_rx  = b;
            m_rda = 1'b1;
        end else begin
`ifdef SPART_FERR_EN
            m_ferr = 1'b1;
`endif
        end
    endtask

    task automatic wait_tx_done(input int budget);
        int k;
        k = 0;
        while ((tx_exp_q.size() != 0 || tx_busy) && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_timeout: %0d frames still pending", tx_exp_q.size());
        end
    endtask

    initial begin
        logic [7:0] b, b2;
        logic       stop;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {15'h0, txd}, 16'h1);
        check("reset_tbr", {15'h0, tbr}, 16'h1);
        check("reset_rda", {15'h0, rda}, 16'h0);
        rst_n = 1'b1;
        read_status();
        bus_read(2'b10, 8'h00);
        bus_read(2'b11, 8'h00);

        // TX of A5 at 64 clocks per bit
        set_div(16'd3);
        tx_exp_q.push_back(8'hA5);
        bus_write(2'b00, 8'hA5);
        check("tbr_after_load", {15'h0, tbr}, 16'h0);
        wait_tx_done(2000);

        // RX of 3C, read clears rda
        drive_rx(8'h3C, 1'b1);
        read_status();
        read_data();
        read_status();

        // Back-to-back writes: the second is refused
        b  = 8'($urandom);
        b2 = 8'($urandom);
        tx_exp_q.push_back(b);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; tb_data = b; tb_drive = 1'b1;
        @(posedge clk); #1;
        tb_data = b2;
        @(posedge clk); #1;
        iocs = 1'b0; tb_drive = 1'b0;
        wait_tx_done(2000);
        repeat (3 * bit_clks) @(posedge clk);

        // Short glitch is a false start, then a real byte
        @(posedge clk); #1;
        rxd = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2 * bit_clks) @(posedge clk);
        read_status();
        drive_rx(8'($urandom), 1'b1);
        read_status();
        read_data();

        // Bad stop bit: byte dropped
        drive_rx(8'($urandom), 1'b0);
        read_status();
        read_status();

        // Random mixed traffic, including overruns and framing errors
        for (int it = 0; it < 12; it++) begin
            set_div(16'($urandom_range(0, 3)));
            b = 8'($urandom);
            tx_exp_q.push_back(b);
            bus_write(2'b00, b);
            stop = ($urandom_range(0, 5) != 0);
            drive_rx(8'($urandom), stop);
            wait_tx_done(4000);
            read_status();
            if ($urandom_range(0, 1) == 1) read_data();
        end

        read_status();
        repeat (3 * bit_clks) @(posedge clk);
        check("tx_queue_drained", 16'(tx_exp_q.size()), 16'h0);
        check("read_queue_drained", 16'(rd_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
